i2c_domain_arbiter: RTL and testbench
=====================================

I2C_DOMAIN_ARBITER -- requirements
Module: i2c_domain_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum cycles in WAIT before the transaction is aborted (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-004 SHALL have ports req0 / req1, input, 1 bit each: read request from requester 0 / 1, held at level until the matching rvalid.
REQ-005 SHALL have ports addr0 / addr1, input, 7 bits each: target slave address of each request.
REQ-006 SHALL have ports gnt0 / gnt1, output, 1 bit each: owning requester's grant, high from GRANT through RESP.
REQ-007 SHALL have ports rdata0 / rdata1, output, 8 bits each: last read byte delivered to that requester.
REQ-008 SHALL have ports rvalid0 / rvalid1, output, 1 bit each: one-cycle response strobe.
REQ-009 SHALL have ports err0 / err1, output, 1 bit each: one-cycle timeout strobe, coincident with rvalid.
REQ-010 SHALL have port sys_start, output, 1 bit: one-cycle start pulse to the shared I2C sequencer.
REQ-011 SHALL have port sys_slave_addr, output, 7 bits: slave address to the sequencer.
REQ-012 SHALL have ports sys_done (input, 1 bit) and sys_rdata (input, 8 bits): sequencer completion strobe and read byte.
REQ-013 SHALL have port domain, output, 1 bit: index of the current owner; drives the downstream domain select.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, GRANT, START, WAIT, RESP; all outputs registered.
REQ-016 IDLE: sample req0/req1; if either is high, go to GRANT next cycle with the owner chosen per REQ-017.
REQ-017 Arbitration SHALL be round-robin via a last_served bit: when both request, the requester not last served wins; a lone requester always wins.
REQ-018 GRANT: latch owner address into sys_slave_addr, assert gnt of owner and domain=owner, go to START.
REQ-019 START: sys_start=1 for exactly this cycle, go to WAIT; sys_done SHALL be ignored outside WAIT.
REQ-020 WAIT: timeout counter increments each cycle from 0. On sys_done, capture sys_rdata into owner's rdata and go to RESP. If the counter reaches TIMEOUT_CYCLES-1 without sys_done, load owner's rdata with 8'h00, set err and go to RESP. If both occur in the same cycle, sys_done wins and err stays low.
REQ-021 RESP: rvalid (and err if set) of owner high for one cycle, update last_served=owner, deassert gnt, go to IDLE. A new grant SHALL NOT occur earlier than the cycle after RESP.
REQ-022 Latency: req sampled in IDLE at cycle t gives gnt at t+1 and sys_start at t+2. sys_done at cycle d gives rvalid at d+1.
REQ-023 Isolation: rdata of the non-owner SHALL never change. rdataX holds its value between responses. sys_slave_addr SHALL be 7'h00 in IDLE.
REQ-024 Dropping req mid-transaction SHALL NOT abort it; the response is still delivered.
REQ-025 addrX changes after GRANT SHALL NOT affect sys_slave_addr.
REQ-026 domain SHALL hold the last owner while in IDLE.

Reset
REQ-027 While rst is high at a clock edge, next-state values are: state IDLE; all gnt, rvalid, err, sys_start and busy 0; rdata0/rdata1 8'h00; sys_slave_addr 7'h00; domain 0; timeout counter 0.
REQ-028 Reset SHALL set last_served=1, so requester 0 wins the first contention.
REQ-029 Reset asserted mid-transaction SHALL discard that transaction with no rvalid or err pulse.

Verification
REQ-030 Single request: req0=1, addr0=7'h10; sequencer returns 8'h12 at sys_done. Expect gnt0 at t+1, sys_start at t+2 with sys_slave_addr=7'h10, rvalid0 with rdata0=8'h12 one cycle after sys_done, rdata1 unchanged.
REQ-031 Contention after reset: req0 and req1 high in the same cycle. Expect requester 0 served first, then requester 1 (addr1=7'h20, data 8'h90). Both held high again: expect alternation 0,1,0,1.
REQ-032 Timeout: TIMEOUT_CYCLES=8, no sys_done. Expect err0 and rvalid0 on the same cycle, rdata0=8'h00, then IDLE.
REQ-033 Same-cycle sys_done and timeout expiry: expect rvalid with captured data and err low.
REQ-034 Reset mid-WAIT and stray sys_done: rst pulsed in WAIT gives no rvalid and all outputs at reset values. sys_done pulsed during IDLE or START gives no effect.

Source files
------------

// File: rtl/i2c_domain_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_domain_arbiter
// Shares one I2C read sequencer between two requesters. A round-robin
// arbiter picks an owner, hands its slave address to the sequencer, waits
// (with timeout) for the read byte and returns it to the owner only.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   req0/req1, addr0/addr1   : level read requests and target addresses
//   gnt0/gnt1                : owner grant, GRANT through RESP
//   rdata0/rdata1            : last byte delivered to each requester
//   rvalid0/rvalid1          : one-cycle response strobe
//   err0/err1                : one-cycle timeout strobe (with rvalid)
//   sys_start, sys_slave_addr: sequencer start pulse and address
//   sys_done, sys_rdata      : sequencer completion strobe and byte
//   domain                   : current/last owner index
//   busy                     : high outside IDLE
// ---------------------------------------------------------------------------
module i2c_domain_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic       err0,
    output logic       err1,
    output logic       sys_start,
    output logic [6:0] sys_slave_addr,
    input  logic       sys_done,
    input  logic [7:0] sys_rdata,
    output logic       domain,
    output logic       busy
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t        state_r,  state_s;
    logic          owner_r,  owner_s;
    logic          last_r,   last_s;
    logic [CW-1:0] cnt_r,    cnt_s;
    logic          gnt0_r,   gnt0_s,   gnt1_r,   gnt1_s;
    logic [7:0]    rdata0_r, rdata0_s, rdata1_r, rdata1_s;
    logic          rvalid0_r, rvalid0_s, rvalid1_r, rvalid1_s;
    logic          err0_r,   err0_s,   err1_r,   err1_s;
    logic          start_r,  start_s;
    logic [6:0]    saddr_r,  saddr_s;
    logic          busy_r,   busy_s;

    // Next-state and next-output computation; pulses default low, state holds.
    always_comb begin
        state_s   = state_r;
        owner_s   = owner_r;
        last_s    = last_r;
        cnt_s     = cnt_r;
        gnt0_s    = gnt0_r;
        gnt1_s    = gnt1_r;
        rdata0_s  = rdata0_r;
        rdata1_s  = rdata1_r;
        rvalid0_s = 1'b0;
        rvalid1_s = 1'b0;
        err0_s    = 1'b0;
        err1_s    = 1'b0;
        start_s   = 1'b0;
        saddr_s   = saddr_r;
        case (state_r)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // Contention goes to whoever was not served last.
                    owner_s = (req0 && req1) ? ~last_r : req1;
                    gnt0_s  = ~owner_s;
                    gnt1_s  = owner_s;
                    state_s = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                saddr_s = owner_r ? addr1 : addr0;
                start_s = 1'b1;
                state_s = ST_START;
            end
            ST_START: begin
                cnt_s   = {CW{1'b0}};
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // sys_done is checked first so it wins over a same-cycle expiry.
                if (sys_done) begin
                    if (owner_r) begin
                        rdata1_s  = sys_rdata;
                        rvalid1_s = 1'b1;
                    end else begin
                        rdata0_s  = sys_rdata;
                        rvalid0_s = 1'b1;
                    end
                    state_s = ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    if (owner_r) begin
                        rdata1_s  = 8'h00;
                        rvalid1_s = 1'b1;
                        err1_s    = 1'b1;
                    end else begin
                        rdata0_s  = 8'h00;
                        rvalid0_s = 1'b1;
                        err0_s    = 1'b1;
                    end
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_RESP: begin
                last_s  = owner_r;
                gnt0_s  = 1'b0;
                gnt1_s  = 1'b0;
                saddr_s = 7'h00;
                cnt_s   = {CW{1'b0}};
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                gnt0_s  = 1'b0;
                gnt1_s  = 1'b0;
                saddr_s = 7'h00;
                cnt_s   = {CW{1'b0}};
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            owner_r   <= 1'b0;
            last_r    <= 1'b1;
            cnt_r     <= {CW{1'b0}};
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            rdata0_r  <= 8'h00;
            rdata1_r  <= 8'h00;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            err0_r    <= 1'b0;
            err1_r    <= 1'b0;
            start_r   <= 1'b0;
            saddr_r   <= 7'h00;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            owner_r   <= owner_s;
            last_r    <= last_s;
            cnt_r     <= cnt_s;
            gnt0_r    <= gnt0_s;
            gnt1_r    <= gnt1_s;
            rdata0_r  <= rdata0_s;
            rdata1_r  <= rdata1_s;
            rvalid0_r <= rvalid0_s;
            rvalid1_r <= rvalid1_s;
            err0_r    <= err0_s;
            err1_r    <= err1_s;
            start_r   <= start_s;
            saddr_r   <= saddr_s;
            busy_r    <= busy_s;
        end
    end

    assign gnt0           = gnt0_r;
    assign gnt1           = gnt1_r;
    assign rdata0         = rdata0_r;
    assign rdata1         = rdata1_r;
    assign rvalid0        = rvalid0_r;
    assign rvalid1        = rvalid1_r;
    assign err0           = err0_r;
    assign err1           = err1_r;
    assign sys_start      = start_r;
    assign sys_slave_addr = saddr_r;
    assign domain         = owner_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_i2c_domain_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_domain_arbiter
// Directed self-checking bench for i2c_domain_arbiter (TIMEOUT_CYCLES=8).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_i2c_domain_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [6:0] addr0 = 7'h00, addr1 = 7'h00;
    logic       gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       sys_start, domain, busy;
    logic [6:0] sys_slave_addr;
    logic       sys_done = 1'b0;
    logic [7:0] sys_rdata = 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_rd0 = 8'h00;
    logic [7:0] exp_rd1 = 8'h00;

    i2c_domain_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .err0(err0), .err1(err1),
        .sys_start(sys_start), .sys_slave_addr(sys_slave_addr),
        .sys_done(sys_done), .sys_rdata(sys_rdata),
        .domain(domain), .busy(busy)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rdata();
        chk("rdata0", rdata0, exp_rd0);
        chk("rdata1", rdata1, exp_rd1);
    endtask

    // One full transaction starting from IDLE with requests already applied.
    task automatic serve(input logic who, input logic [6:0] a, input logic [7:0] d);
        tick();
        chk("gnt0", gnt0, who == 1'b0);
        chk("gnt1", gnt1, who == 1'b1);
        chk("domain", domain, who);
        chk("busy_grant", busy, 1'b1);
        chk("start_early", sys_start, 1'b0);
        tick();
        chk("sys_start", sys_start, 1'b1);
        chk("sys_addr", sys_slave_addr, a);
        tick();
        chk("start_once", sys_start, 1'b0);
        sys_done = 1'b1;
        sys_rdata = d;
        tick();
        sys_done = 1'b0;
        chk("rvalid_own", who ? rvalid1 : rvalid0, 1'b1);
        chk("rvalid_other", who ? rvalid0 : rvalid1, 1'b0);
        chk("err_own", who ? err1 : err0, 1'b0);
        if (who) exp_rd1 = d; else exp_rd0 = d;
        chk_rdata();
        tick();
        chk("rvalid_pulse", rvalid0 | rvalid1, 1'b0);
        chk("gnt_off", {gnt1, gnt0}, 2'b00);
        chk("busy_idle", busy, 1'b0);
        chk("addr_idle", sys_slave_addr, 7'h00);
        chk("domain_hold", domain, who);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_rd0 = 8'h00;
        exp_rd1 = 8'h00;
    endtask

    task automatic chk_reset_vals();
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        chk("rst_err", {err1, err0}, 2'b00);
        chk("rst_start", sys_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addr", sys_slave_addr, 7'h00);
        chk("rst_domain", domain, 1'b0);
        chk_rdata();
    endtask

    initial begin
        // Reset state.
        do_reset();
        chk_reset_vals();

        // Single request from requester 0.
        req0 = 1'b1; addr0 = 7'h10;
        serve(1'b0, 7'h10, 8'h12);
        req0 = 1'b0;
        tick();
        chk("single_idle", busy, 1'b0);

        // Contention right after reset: 0 first, then strict alternation.
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 7'h10; addr1 = 7'h20;
        serve(1'b0, 7'h10, 8'h34);
        serve(1'b1, 7'h20, 8'h90);
        serve(1'b0, 7'h10, 8'h56);
        serve(1'b1, 7'h20, 8'h78);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Timeout: WAIT lasts 8 cycles, then err0 with rvalid0 and zero data.
        req0 = 1'b1; addr0 = 7'h11;
        tick(); tick(); tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_no_rvalid", rvalid0, 1'b0);
        end
        tick();
        chk("to_rvalid0", rvalid0, 1'b1);
        chk("to_err0", err0, 1'b1);
        exp_rd0 = 8'h00;
        chk_rdata();
        req0 = 1'b0;
        tick();
        chk("to_err_pulse", err0, 1'b0);
        chk("to_idle", busy, 1'b0);

        // sys_done on the same cycle as expiry: data wins, no err.
        req0 = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 7; i++) tick();
        sys_done = 1'b1; sys_rdata = 8'h5A;
        tick();
        sys_done = 1'b0;
        chk("tie_rvalid0", rvalid0, 1'b1);
        chk("tie_err0", err0, 1'b0);
        exp_rd0 = 8'h5A;
        chk_rdata();
        req0 = 1'b0;
        tick();

        // Stray sys_done in IDLE does nothing.
        sys_done = 1'b1; sys_rdata = 8'hFF;
        tick(); tick();
        sys_done = 1'b0;
        chk("stray_idle_rv", {rvalid1, rvalid0}, 2'b00);
        chk("stray_idle_busy", busy, 1'b0);
        chk_rdata();

        // Requester 1: done in START ignored, addr change and req drop ignored.
        req1 = 1'b1; addr1 = 7'h33;
        tick();
        chk("r1_gnt1", gnt1, 1'b1);
        tick();
        chk("r1_addr", sys_slave_addr, 7'h33);
        sys_done = 1'b1; sys_rdata = 8'hEE;
        addr1 = 7'h44;
        tick();
        sys_done = 1'b0;
        req1 = 1'b0;
        chk("r1_start_done", {rvalid1, rvalid0}, 2'b00);
        chk("r1_addr_hold", sys_slave_addr, 7'h33);
        chk_rdata();
        tick(); tick();
        chk("r1_still_busy", busy, 1'b1);
        sys_done = 1'b1; sys_rdata = 8'h77;
        tick();
        sys_done = 1'b0;
        chk("r1_rvalid1", rvalid1, 1'b1);
        exp_rd1 = 8'h77;
        chk_rdata();
        tick();
        chk("r1_domain_idle", domain, 1'b1);

        // Reset mid-WAIT discards the transaction.
        req0 = 1'b1; addr0 = 7'h55;
        tick(); tick(); tick(); tick();
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1; req0 = 1'b0;
        tick();
        rst = 1'b0;
        exp_rd0 = 8'h00; exp_rd1 = 8'h00;
        chk_reset_vals();
        tick(); tick();
        chk("mid_no_rvalid", {rvalid1, rvalid0, err1, err0}, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
